// File: rtl/eth_mdio_master.sv
// ---------------------------------------------------------------------------
// eth_mdio_master
//
// Clause-22 MDIO management master for the RMII PHY. It runs one register
// read or write frame per accepted command and reports completion with a
// single-cycle o_done pulse.
//
// Build option:
//   ETH_MDIO_PREAMBLE_EN  defined   -> 32-bit preamble sent (65 bit periods)
//                         undefined -> preamble suppressed (33 bit periods)
//
// Parameter:
//   CLK_DIV     MDC half-period in clk50 cycles (legal range 4..255)
//
// Ports:
//   clk50       system clock, sole clock
//   rst_n       synchronous active-low reset
//   i_start     1-cycle command strobe, taken only while o_busy = 0
//   i_rd        1 = read, 0 = write
//   i_phyaddr   PHY address (5 bits)
//   i_regaddr   register address (5 bits)
//   i_wdata     write data (16 bits)
//   o_busy      frame in progress
//   o_done      1-cycle pulse at end of frame
//   o_rdata     read data, valid from o_done until the next accepted i_start
//   o_err       read turnaround not acknowledged by the PHY
//   o_mdc       MDC pin
//   o_mdio_out  MDIO drive value
//   o_mdio_oe   MDIO output enable
//   i_mdio_in   MDIO pad input (asynchronous)
// ---------------------------------------------------------------------------
module eth_mdio_master #(
  parameter int CLK_DIV = 10
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_rd,
  input  logic [4:0]  i_phyaddr,
  input  logic [4:0]  i_regaddr,
  input  logic [15:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_err,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  input  logic        i_mdio_in
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_ST,
    S_OP,
    S_PHY,
    S_REG,
    S_TA,
    S_DATA,
    S_END
  } state_t;

  // A bit period is 2*CLK_DIV cycles: MDC low for the first half, high for
  // the second. DIV_RISE is the last low cycle; MDC rises at the edge that
  // ends it, and that same edge captures the synchronised input.
  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0] DIV_RISE = 9'(CLK_DIV - 1);
  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [8:0]  div_cnt_reg, div_cnt_next;
  logic        mdc_reg;
  logic        mdio_out_reg, mdio_oe_reg;
  logic        busy_reg, done_reg;
  logic [15:0] rdata_reg;
  logic        err_reg;
  logic        rd_reg;
  logic [4:0]  phyaddr_reg, regaddr_reg;
  logic [15:0] wdata_reg;
  logic [1:0]  mdio_sync_reg;

  logic        accept;
  logic        bit_end;
  logic        sample_rise;
  logic        frame_end;
  logic        drv_out, drv_oe;

  assign accept      = i_start && (state_reg == S_IDLE);
  assign bit_end     = (state_reg != S_IDLE) && (div_cnt_reg == DIV_LAST);
  assign sample_rise = (state_reg != S_IDLE) && (div_cnt_reg == DIV_RISE);
  assign frame_end   = bit_end && (state_reg == S_END);

  // Next state and per-state bit counter. Each field loads its length-1 on
  // entry and counts down; the field ends on the last cycle of the bit
  // period in which the counter is 0.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
`ifdef ETH_MDIO_PREAMBLE_EN
          state_next   = S_PRE;
          bit_cnt_next = 5'd31;
`else
          state_next   = S_ST;
          bit_cnt_next = 5'd1;
`endif
        end
      end
      default: begin
        if (bit_end) begin
          if (bit_cnt_reg != 5'd0) begin
            bit_cnt_next = bit_cnt_reg - 5'd1;
          end else begin
            unique case (state_reg)
              S_PRE:   begin state_next = S_ST;   bit_cnt_next = 5'd1;  end
              S_ST:    begin state_next = S_OP;   bit_cnt_next = 5'd1;  end
              S_OP:    begin state_next = S_PHY;  bit_cnt_next = 5'd4;  end
              S_PHY:   begin state_next = S_REG;  bit_cnt_next = 5'd4;  end
              S_REG:   begin state_next = S_TA;   bit_cnt_next = 5'd1;  end
              S_TA:    begin state_next = S_DATA; bit_cnt_next = 5'd15; end
              S_DATA:  begin state_next = S_END;  bit_cnt_next = 5'd0;  end
              default: begin state_next = S_IDLE; bit_cnt_next = 5'd0;  end
            endcase
          end
        end
      end
    endcase
  end

  // Divider: held at 0 in IDLE so the first bit starts with a full low half.
  always_comb begin
    div_cnt_next = div_cnt_reg + 9'd1;
    if ((state_reg == S_IDLE) || bit_end) begin
      div_cnt_next = 9'd0;
    end
  end

  // Value to put on the pin for the bit about to start. It is evaluated for
  // the upcoming (state, count) and registered at the bit boundary, so the
  // pin changes on the same cycle MDC goes low. The first bit after accept
  // is PRE or ST, neither of which depends on the command still being
  // latched in the same edge.
  always_comb begin
    drv_out = 1'b1;
    drv_oe  = 1'b0;
    unique case (state_next)
      S_PRE: begin
        drv_out = 1'b1;
        drv_oe  = 1'b1;
      end
      S_ST: begin
        drv_out = ~bit_cnt_next[0];                // 0 then 1
        drv_oe  = 1'b1;
      end
      S_OP: begin
        drv_out = rd_reg ? bit_cnt_next[0] : ~bit_cnt_next[0];  // 10 / 01
        drv_oe  = 1'b1;
      end
      S_PHY: begin
        drv_out = phyaddr_reg[bit_cnt_next[2:0]];
        drv_oe  = 1'b1;
      end
      S_REG: begin
        drv_out = regaddr_reg[bit_cnt_next[2:0]];
        drv_oe  = 1'b1;
      end
      S_TA: begin
        drv_out = rd_reg ? 1'b1 : bit_cnt_next[0];  // write: 1 then 0
        drv_oe  = ~rd_reg;
      end
      S_DATA: begin
        drv_out = rd_reg ? 1'b1 : wdata_reg[bit_cnt_next[3:0]];
        drv_oe  = ~rd_reg;
      end
      default: begin
        drv_out = 1'b1;
        drv_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= 5'd0;
      div_cnt_reg   <= 9'd0;
      mdc_reg       <= 1'b0;
      mdio_out_reg  <= 1'b1;
      mdio_oe_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rdata_reg     <= 16'h0000;
      err_reg       <= 1'b0;
      rd_reg        <= 1'b0;
      phyaddr_reg   <= 5'd0;
      regaddr_reg   <= 5'd0;
      wdata_reg     <= 16'h0000;
      mdio_sync_reg <= 2'b11;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      div_cnt_reg   <= div_cnt_next;
      mdc_reg       <= (div_cnt_next >= DIV_HALF);
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= frame_end;
      mdio_sync_reg <= {mdio_sync_reg[0], i_mdio_in};

      if (accept || bit_end) begin
        mdio_out_reg <= drv_out;
        mdio_oe_reg  <= drv_oe;
      end

      if (accept) begin
        rd_reg      <= i_rd;
        phyaddr_reg <= i_phyaddr;
        regaddr_reg <= i_regaddr;
        wdata_reg   <= i_wdata;
        err_reg     <= 1'b0;
      end

      // Read capture. DATA is shifted in even after a failed turnaround so
      // an absent PHY reads back as all ones from the pad pull-up.
      if (sample_rise && rd_reg) begin
        if ((state_reg == S_TA) && (bit_cnt_reg == 5'd0) && mdio_sync_reg[1]) begin
          err_reg <= 1'b1;
        end
        if (state_reg == S_DATA) begin
          rdata_reg <= {rdata_reg[14:0], mdio_sync_reg[1]};
        end
      end
    end
  end

  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_rdata    = rdata_reg;
  assign o_err      = err_reg;
  assign o_mdc      = mdc_reg;
  assign o_mdio_out = mdio_out_reg;
  assign o_mdio_oe  = mdio_oe_reg;

endmodule

// File: doc/eth_mdio_master.md
# eth_mdio_master

- **Function:** Clause-22 MDIO management master for the RMII PHY.
- **Role:** Sequences single register read/write frames to the PHY on behalf of a host. In practice this is the JTAG debug port or a local bring-up FSM.
- **Placement:** Sits beside `eth_rmii_rx` in the `clk50` domain. It replaces the tied-off `phy0_mdc`/`phy0_mdio` pins.
- **Pin wiring:** The top level uses `o_mdio_out`/`o_mdio_oe` to build the tristate pad and feeds the pad into `i_mdio_in`.

## Interface
- `CLK_DIV`, default 10: MDC half-period in `clk50` cycles (2.5 MHz MDC at 50 MHz). Legal range 4..255.
- Clocking and reset (already decided): one clock, `clk50`; reset is synchronous and active-low, `rst_n`.
- `clk50`  in  1  system clock, sole clock
- `rst_n`  in  1  synchronous active-low reset
- `i_start`  in  1  1-cycle command strobe; accepted only when `o_busy`=0
- `i_rd`  in  1  1 = read, 0 = write
- `i_phyaddr`  in  5  PHY address
- `i_regaddr`  in  5  register address
- `i_wdata`  in  16  write data
- `o_busy`  out  1  frame in progress
- `o_done`  out  1  1-cycle pulse at end of frame
- `o_rdata`  out  16  read data; valid from `o_done` until the next accepted `i_start`
- `o_err`  out  1  read turnaround not acknowledged; valid with `o_rdata`
- `o_mdc`  out  1  MDC pin
- `o_mdio_out`  out  1  MDIO drive value
- `o_mdio_oe`  out  1  MDIO output enable
- `i_mdio_in`  in  1  MDIO pad input (asynchronous)

## Operation
- **Command acceptance:** On `i_start` & !`o_busy`, latch `i_rd`, `i_phyaddr`, `i_regaddr` and `i_wdata`, then clear `o_err`. `i_start` while busy is ignored with no side effects.
- **State sequence:** IDLE → PRE (32 bits of 1) → ST (01) → OP (read 10, write 01) → PHY (5 bits, MSB first) → REG (5 bits, MSB first) → TA → DATA (16 bits, MSB first) → END (1 bit) → IDLE.
- **Per-state bit counter:** 5-bit; each state exits when its count expires.
- **TA, write:** drive 1 then 0 (`o_mdio_oe`=1).
- **TA, read:** `o_mdio_oe`=0 for both bits. The sampled second TA bit must be 0; if it is 1, set `o_err`=1.
- **DATA, write:** drive the latched `i_wdata`.
- **DATA, read:** `o_mdio_oe`=0; shift sampled bits into `o_rdata`, MSB first. This is done even on error, so a missing PHY reads 0xFFFF with the pad pull-up.
- **END:** `o_mdio_oe`=0 and `o_mdio_out`=1 for one bit period. Then pulse `o_done` and drop `o_busy` in the same cycle.
- **Input synchronisation:** `i_mdio_in` passes through a 2-flop synchroniser before use.
- **Reset mid-frame:** abort immediately. All outputs return to reset values on the cycle after `rst_n` is sampled low. No `o_done` is produced.

## Timing
- **Reset values:**
  - `o_mdc`=0, `o_mdio_out`=1, `o_mdio_oe`=0
  - `o_busy`=0, `o_done`=0, `o_rdata`=0, `o_err`=0
- **Bit period:** 2·`CLK_DIV` cycles.
  - MDC is low for the first `CLK_DIV` cycles and high for the second `CLK_DIV` cycles.
  - The MDC level comes from a registered divider counter; the counter is held at 0 in IDLE.
- **Drive timing:** `o_mdio_out`/`o_mdio_oe` update on the same cycle MDC goes low, i.e. the first cycle of each bit.
- **Sample timing:** capture the synchronised input on the cycle MDC goes 0→1. This samples data the PHY launched after the previous MDC rise.
- **Start latency:** `o_busy`=1 and the first bit is driven on the cycle after `i_start` is accepted.
- **Frame length:** 65 bit periods with preamble, 33 without. `o_done` is asserted on the cycle after the last END cycle.
- **Back-to-back frames:** a new `i_start` is legal on the cycle `o_done`=1 (`o_busy` is already 0 that cycle).
- **`o_mdc` between frames:** remains 0 in IDLE.

## Configuration
- **Macro:** `ETH_MDIO_PREAMBLE_EN`.
- **Defined:** the PRE state is emitted (32 ones before ST); frame = 65 bit periods.
- **Undefined:** PRE is skipped, so IDLE → ST directly (preamble suppression; the PHY must support it); frame = 33 bit periods.
- **Scope of effect:** all other states, timing and outputs are identical in both builds.

## Test plan
- **Write frame (CLK_DIV=4, preamble on):**
  - Stimulus: `i_phyaddr`=1, `i_regaddr`=0, `i_wdata`=0x3100.
  - Response: capture MDIO at each MDC rise; the bit stream equals 32×1, 01, 01, 00001, 00000, 10, 0x3100 MSB first.
  - Response: `o_done` arrives 520 cycles after the start cycle + 1; `o_err`=0.
- **Read frame with PHY model:**
  - Stimulus: PHY model drives TA=Z,0 then 0x796D; `i_regaddr`=2.
  - Response: `o_rdata`=0x796D and `o_err`=0 at `o_done`; `o_mdio_oe`=0 throughout TA/DATA.
- **Read with no PHY:**
  - Stimulus: pad pulled high.
  - Response: `o_rdata`=0xFFFF and `o_err`=1 at `o_done`.
- **Start while busy:**
  - Stimulus: second `i_start` at mid-PHY-field with different addresses.
  - Response: the frame in flight is unchanged; exactly one `o_done`; `o_busy` never deasserts early.
- **Reset mid-DATA:**
  - Stimulus: assert `rst_n`=0 for 1 cycle.
  - Response: the next cycle shows all reset values and no `o_done`; a new write then completes normally.
- **Preamble compiled out:**
  - Stimulus: build without `ETH_MDIO_PREAMBLE_EN`, CLK_DIV=4, run a write frame.
  - Response: the first captured bits are 01 (ST); `o_done` arrives 264 cycles after the start cycle + 1.
